fetch_stage_ctrl: RTL
=====================

// Module: fetch_stage_ctrl
// PURPOSE
//  Consumer end of the hazard stall/flush protocol. Owns PC, the p2 instruction register and the imem req/ack handshake.
//  Obeys pcWren/irWren (stall) and irFlush (branch squash + redirect) from the hazard detection unit.
//  Sits between instruction memory and decode. Absorbs variable imem latency and buffers a word fetched during a stall.
// PARAMETERS
//  DATA_W    16     instruction width
//  ADDR_W    16     PC / imem address width
//  RESET_PC  16'h0  PC value after reset
//  NOP_INSN  16'h0  bubble inserted into ir on flush/no-word
// PORTS
//  clock          in   1       single clock, rising edge
//  reset_n        in   1       asynchronous, active-low reset
//  pcWren         in   1       1=PC may advance; 0=stall
//  irWren         in   1       1=ir may load; 0=hold ir
//  irFlush        in   1       squash ir and redirect PC to branch_target
//  branch_target  in   ADDR_W  redirect address, valid with irFlush
//  imem_req       out  1       fetch request
//  imem_addr      out  ADDR_W  fetch address, stable while imem_req=1
//  imem_ack       in   1       word valid on imem_rdata this cycle
//  imem_rdata     in   DATA_W  fetched word
//  ir             out  DATA_W  p2 instruction register
//  ir_pc          out  ADDR_W  address of word in ir (PC+1 for branches computed downstream)
//  ir_valid       out  1       ir holds a real instruction (0=bubble)
// BEHAVIOUR
//  Reset (async, reset_n=0): pc=RESET_PC; ir=NOP_INSN; ir_pc=0; ir_valid=0; imem_req=0; state=BOOT; buffer empty.
//  States: BOOT -> FETCH (first cycle after reset release, no req); FETCH: imem_req=1, imem_addr=pc;
//   BUFFERED: word held, imem_req=0; DISCARD: req outstanding to stale addr, imem_req=1 with old addr.
//  Handshake: once imem_req rises, imem_addr and imem_req hold until the imem_ack cycle. Never withdrawn early. One outstanding request max.
//  Word available this cycle = (FETCH & imem_ack) | BUFFERED.
//  Advance = pcWren & irWren & word available & ~irFlush. On advance: ir<=word, ir_pc<=pc, ir_valid<=1, pc<=pc+1, buffer cleared.
//   The next request issues in the same cycle, so back-to-back 0-wait acks give one instruction per cycle.
//  Stall (pcWren=0 or irWren=0), no flush:
//   - irWren=0: ir/ir_pc/ir_valid hold.
//   - ack arrives: word latched into buffer, state->BUFFERED, pc holds.
//  irWren=1, no word, no flush: ir<=NOP_INSN, ir_valid<=0 (bubble); pc holds.
//  irFlush=1 (priority over stall and ack):
//   - ir<=NOP_INSN, ir_valid<=0; pc<=branch_target; buffer dropped.
//   - Request outstanding without ack this cycle -> DISCARD. Else -> FETCH at branch_target next cycle.
//  DISCARD: on imem_ack, data dropped -> FETCH (new pc). Further irFlush in DISCARD only updates pc.
//  Pipeline latency: word acked in cycle t appears on ir at t+1 when not stalled.
//  PC arithmetic: pc+1 mod 2^ADDR_W. 16'hFFFF wraps to 16'h0000 silently.
//  Simultaneous: irFlush + imem_ack in FETCH -> acked word dropped, no DISCARD needed.
//   pcWren/irWren disagreeing counts as stall.
//  Reset mid-request: outstanding transaction abandoned. Imem must tolerate a req drop on reset only.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs stall_cnt[15:0] (cycles with pcWren=0 | irWren=0) and flush_cnt[15:0] (cycles with irFlush=1).
//   Counters are saturating, reset 0.
//  Undefined: these ports and counters are absent. Core behaviour is identical.
// TESTING
//  1 reset, imem acks 0-wait, mem[n]=16'h1000+n -> ir=16'h1000,16'h1001,16'h1002 on successive cycles, ir_pc=0,1,2, ir_valid=1.
//  2 imem ack after 3 waits -> imem_addr stable 4 cycles. ir_valid=0 bubbles for 3 cycles, then ir=16'h1000.
//  3 pcWren=irWren=0 for 2 cycles while ack of addr 5 arrives -> ir holds, state BUFFERED, imem_req=0.
//    On release ir=16'h1005 and next req addr=6.
//  4 irFlush=1, branch_target=16'h0040 with no outstanding req -> ir=NOP_INSN, ir_valid=0.
//    Next cycle imem_addr=16'h0040.
//  5 irFlush during 2-wait request to addr 7 -> req holds addr 7 until ack, data dropped.
//    Then req addr 16'h0040; addr-7 word never reaches ir.
//  6 pc=16'hFFFF advance -> next imem_addr=16'h0000. With FETCH_PERF_CNT_EN, 3 stall cycles -> stall_cnt=3.

Source files
------------

// File: rtl/fetch_stage_ctrl.sv
// ============================================================================
// Module     : fetch_stage_ctrl
// Description: Fetch stage at the consumer end of the hazard stall/flush
//              protocol. Owns the PC, the p2 instruction register and the
//              instruction-memory req/ack handshake. Absorbs variable imem
//              latency and buffers a word that arrives during a stall.
//              Optional macro FETCH_PERF_CNT_EN adds saturating stall/flush
//              cycle counters (stall_cnt, flush_cnt).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage_ctrl #(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [DATA_W-1:0]  NOP_INSN = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pcWren,
  input  logic              irWren,
  input  logic              irFlush,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam logic [1:0] S_BOOT     = 2'd0;
  localparam logic [1:0] S_FETCH    = 2'd1;
  localparam logic [1:0] S_BUFFERED = 2'd2;
  localparam logic [1:0] S_DISCARD  = 2'd3;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] disc_addr_q, disc_addr_d;   // stale address of a squashed request
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;

  logic              word_avail;
  logic [DATA_W-1:0] word;
  logic              advance;

  // A word is usable when it is acked right now or was parked during a stall
  assign word_avail = ((state_q == S_FETCH) & imem_ack) | (state_q == S_BUFFERED);
  assign word       = (state_q == S_BUFFERED) ? buf_q : imem_rdata;
  assign advance    = pcWren & irWren & word_avail & ~irFlush;

  // Request stays up with a frozen address until acked; DISCARD keeps the old address
  assign imem_req  = (state_q == S_FETCH) | (state_q == S_DISCARD);
  assign imem_addr = (state_q == S_DISCARD) ? disc_addr_q : pc_q;

  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;

  // Next-state: flush beats everything, then discard drain, advance, stall/bubble
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    disc_addr_d = disc_addr_q;
    buf_d       = buf_q;
    ir_d        = ir_q;
    ir_pc_d     = ir_pc_q;
    ir_valid_d  = ir_valid_q;

    if (state_q == S_BOOT) begin
      state_d = S_FETCH;
      if (irFlush) begin
        pc_d = branch_target;
      end
      if (irWren | irFlush) begin
        ir_d       = NOP_INSN;
        ir_valid_d = 1'b0;
      end
    end else if (irFlush) begin
      ir_d       = NOP_INSN;
      ir_valid_d = 1'b0;
      pc_d       = branch_target;
      if (imem_req & ~imem_ack) begin
        // Memory still owes us a word for the old address; drain it first
        state_d = S_DISCARD;
        if (state_q == S_FETCH) begin
          disc_addr_d = pc_q;
        end
      end else begin
        state_d = S_FETCH;
      end
    end else if (state_q == S_DISCARD) begin
      if (imem_ack) begin
        state_d = S_FETCH;
      end
      if (irWren) begin
        ir_d       = NOP_INSN;
        ir_valid_d = 1'b0;
      end
    end else if (advance) begin
      ir_d       = word;
      ir_pc_d    = pc_q;
      ir_valid_d = 1'b1;
      pc_d       = pc_q + PC_ONE;
      state_d    = S_FETCH;
    end else begin
      if (irWren) begin
        ir_d       = NOP_INSN;
        ir_valid_d = 1'b0;
      end
      if ((state_q == S_FETCH) & imem_ack) begin
        buf_d   = imem_rdata;
        state_d = S_BUFFERED;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      disc_addr_q <= '0;
      buf_q       <= '0;
      ir_q        <= NOP_INSN;
      ir_pc_q     <= '0;
      ir_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      disc_addr_q <= disc_addr_d;
      buf_q       <= buf_d;
      ir_q        <= ir_d;
      ir_pc_q     <= ir_pc_d;
      ir_valid_q  <= ir_valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Saturating counts of stall cycles and flush cycles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((~pcWren | ~irWren) && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (irFlush && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

`default_nettype wire
